video_mode_detect: RTL

- Measures incoming shifter sync timing (lines per frame, clocks per line) and classifies the ST video mode: 0 = NTSC, 1 = PAL, 2 = mono/high.
- Sits directly upstream of the video output stage and feeds its `vmode` and `vreset` inputs. Those drive the scandoubler bypass and the LCD DE window offsets.
- A mode is committed only after it has been seen stably for several consecutive frames. Each commit, and each wide-screen toggle, produces a `vreset` pulse.

---
 rtl/video_pkg.sv | 37 +++
 rtl/video_mode_detect_sync_edge.sv | 25 ++
 rtl/video_mode_detect.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Shared video definitions: mode codes, mode-detector states and line thresholds.
package video_pkg;

  localparam logic [1:0] MODE_NTSC = 2'd0;
  localparam logic [1:0] MODE_PAL  = 2'd1;
  localparam logic [1:0] MODE_HIGH = 2'd2;

  // Line-count thresholds, also used by the DE-window logic downstream
  localparam int unsigned DEF_MIN_LINES      = 200;
  localparam int unsigned DEF_PAL_MIN_LINES  = 290;
  localparam int unsigned DEF_HIGH_MIN_LINES = 400;

  typedef enum logic [1:0] {
    WAIT_FIRST,
    TRACK,
    COMMIT
  } vmd_state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] cls;
  } frame_class_t;

  // A saturated count (all ones) means vsync went missing, so it is never valid
  function automatic frame_class_t classify_frame(input logic [9:0] n,
                                                  input int unsigned min_l,
                                                  input int unsigned pal_l,
                                                  input int unsigned high_l);
    frame_class_t r;
    r.valid = (32'(n) >= min_l) && (n != '1);
    if (32'(n) >= high_l)     r.cls = MODE_HIGH;
    else if (32'(n) >= pal_l) r.cls = MODE_PAL;
    else                      r.cls = MODE_NTSC;
    return r;
  endfunction

endpackage

// File: rtl/video_mode_detect_sync_edge.sv
// Registers an active-low sync input and flags its falling edge.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic sync_n,
  output logic fall
);

  logic sync_q;
  logic last_q;

  // Input register plus one history stage; idle level of a sync is high
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 1'b1;
      last_q <= 1'b1;
    end else begin
      sync_q <= sync_n;
      last_q <= sync_q;
    end
  end

  assign fall = last_q & ~sync_q;

endmodule

// File: rtl/video_mode_detect.sv
// Measures shifter sync timing, classifies the ST video mode and commits it
// once it has been seen on several consecutive frames.
module video_mode_detect
  import video_pkg::*;
#(
  parameter int unsigned STABLE_FRAMES  = 3,
  parameter int unsigned VRESET_LEN     = 16,
  parameter int unsigned PAL_MIN_LINES  = DEF_PAL_MIN_LINES,
  parameter int unsigned HIGH_MIN_LINES = DEF_HIGH_MIN_LINES,
  parameter int unsigned MIN_LINES      = DEF_MIN_LINES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vs_n,
  input  logic        hs_n,
  input  logic        de,
  input  logic        wide,
  output logic [1:0]  mode,
  output logic        vreset,
  output logic        stable,
  output logic [9:0]  lines,
  output logic [9:0]  active_lines,
  output logic [11:0] line_clks
);

  localparam int unsigned CNT_W = $clog2(STABLE_FRAMES + 1);
  localparam int unsigned VR_W  = $clog2(VRESET_LEN + 1);

  logic             hs_fall;
  logic             vs_fall;
  logic [11:0]      clk_cnt;
  logic [9:0]       line_cnt;
  logic [9:0]       act_cnt;
  logic             de_flag;
  vmd_state_t       state, state_n;
  logic [1:0]       cand, cand_n, mode_n;
  logic [CNT_W-1:0] stab, stab_n;
  logic             stable_n;
  logic             commit;
  frame_class_t     fc;
  logic             wide_q;
  logic [VR_W-1:0]  vr_cnt;

  sync_edge u_hs (.clk(clk), .reset(reset), .sync_n(hs_n), .fall(hs_fall));
  sync_edge u_vs (.clk(clk), .reset(reset), .sync_n(vs_n), .fall(vs_fall));

  // Clocks per line: reports the span between the last two hs edges
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_cnt   <= '0;
      line_clks <= '0;
    end else if (hs_fall) begin
      line_clks <= clk_cnt;
      clk_cnt   <= 12'd1;
    end else if (clk_cnt != '1) begin
      clk_cnt <= clk_cnt + 12'd1;
    end
  end

  // Per-frame line and active-line counters, latched on vsync.
  // An hs edge coincident with vsync opens line 1 of the new frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      line_cnt     <= '0;
      act_cnt      <= '0;
      de_flag      <= 1'b0;
      lines        <= '0;
      active_lines <= '0;
    end else if (vs_fall) begin
      if (state != WAIT_FIRST) begin
        lines        <= line_cnt;
        active_lines <= act_cnt;
      end
      line_cnt <= hs_fall ? 10'd1 : 10'd0;
      act_cnt  <= '0;
      de_flag  <= 1'b0;
    end else if (hs_fall) begin
      if (line_cnt != '1) line_cnt <= line_cnt + 10'd1;
      de_flag <= 1'b0;
    end else if (de && !de_flag) begin
      de_flag <= 1'b1;
      if (act_cnt != '1) act_cnt <= act_cnt + 10'd1;
    end
  end

  assign fc = classify_frame(line_cnt, MIN_LINES, PAL_MIN_LINES, HIGH_MIN_LINES);

  // Mode tracker state and committed outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= WAIT_FIRST;
      mode   <= MODE_NTSC;
      cand   <= MODE_NTSC;
      stab   <= '0;
      stable <= 1'b0;
    end else begin
      state  <= state_n;
      mode   <= mode_n;
      cand   <= cand_n;
      stab   <= stab_n;
      stable <= stable_n;
    end
  end

  // Next-state: count consecutive identical valid classes, commit on a new mode
  always_comb begin
    state_n  = state;
    mode_n   = mode;
    cand_n   = cand;
    stab_n   = stab;
    stable_n = stable;
    commit   = 1'b0;
    case (state)
      WAIT_FIRST: begin
        if (vs_fall) state_n = TRACK;
      end
      TRACK: begin
        if (vs_fall) begin
          if (!fc.valid) begin
            stab_n   = '0;
            stable_n = 1'b0;
          end else begin
            stable_n = (fc.cls == mode);
            if (fc.cls == cand) begin
              if (stab != '1) stab_n = stab + 1'b1;
            end else begin
              cand_n = fc.cls;
              stab_n = CNT_W'(1);
            end
            if ((stab_n >= CNT_W'(STABLE_FRAMES)) && (cand_n != mode)) state_n = COMMIT;
          end
        end
      end
      COMMIT: begin
        mode_n   = cand;
        stable_n = 1'b1;
        commit   = 1'b1;
        state_n  = TRACK;
      end
      default: state_n = WAIT_FIRST;
    endcase
  end

  // vreset pulse: commit or wide change (re)loads the counter; one load if both
  always_ff @(posedge clk) begin
    if (reset) begin
      wide_q <= wide;
      vr_cnt <= '0;
    end else begin
      wide_q <= wide;
      if (commit || (wide != wide_q)) vr_cnt <= VR_W'(VRESET_LEN);
      else if (vr_cnt != '0)          vr_cnt <= vr_cnt - 1'b1;
    end
  end

  assign vreset = (vr_cnt != '0);

endmodule
